apb_mem_ctrl: RTL

APB4 slave controller that sequences the 1024x32 single-port memory (sync write, async read). It decodes APB transfers, drives the memory's address, write enable and write data, and registers read data. It generates wait states and error responses, and performs read-modify-write for partial byte strobes. It sits between the APB interconnect and the memory instance inside the APB memory top level.

---
 rtl/apb_mem_pkg.sv | 38 +++
 rtl/apb_mem_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB memory controller.
// The optional partial-strobe feature is selected by APB_MEM_CTRL_STRB_EN in apb_mem_ctrl.
package apb_mem_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Address error: byte offset not word aligned, or any bit set above the memory's word range.
    function automatic logic addr_err(input logic [63:0] addr, input int addr_w, input int mem_aw);
        logic err;
        err = (addr[1:0] != 2'b00);
        for (int i = 2; i < 64; i++) begin
            if (i >= mem_aw + 2 && i < addr_w && addr[i])
                err = 1'b1;
        end
        return err;
    endfunction

    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] wdata,
                                                     input logic [DATA_W-1:0] rdata,
                                                     input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] merged;
        merged = rdata;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i])
                merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/apb_mem_ctrl.sv
// APB4 slave sequencing a single-port memory (sync write, async read) with wait states and errors.
// Define APB_MEM_CTRL_STRB_EN to enable read-modify-write for partial byte strobes.
module apb_mem_ctrl
    import apb_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    input  logic [3:0]        pstrb,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t state, state_nxt;
    logic   setup;
    logic   err_now;
    logic   err_q;
    logic   write_q;

`ifdef APB_MEM_CTRL_STRB_EN
    logic [STRB_W-1:0] strb_q;
`else
    logic unused_strb;
    assign unused_strb = ^pstrb;
`endif

    assign setup   = psel & ~penable;
    assign err_now = addr_err(64'(paddr), ADDR_W, MEM_AW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every output of this block is given a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        pready    = 1'b0;
        pslverr   = 1'b0;
        mem_we    = 1'b0;
        unique case (state)
            IDLE: begin
                if (setup) begin
                    if (err_now)
                        state_nxt = RESP;
                    else if (!pwrite)
                        state_nxt = READ;
`ifdef APB_MEM_CTRL_STRB_EN
                    else if (pstrb == '0)
                        state_nxt = RESP;
                    else if (pstrb != '1)
                        state_nxt = READ;
`endif
                    else
                        state_nxt = WRITE;
                end
            end
            READ:  state_nxt = write_q ? WRITE : RESP;
            WRITE: begin
                mem_we    = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                pready    = 1'b1;
                pslverr   = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
    // mem_wdata doubles as the staging word: loaded with pwdata at setup, merged in READ for RMW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prdata    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err_q     <= 1'b0;
            write_q   <= 1'b0;
`ifdef APB_MEM_CTRL_STRB_EN
            strb_q    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (setup) begin
                        mem_addr <= paddr[MEM_AW+1:2];
                        err_q    <= err_now;
                        write_q  <= pwrite;
`ifdef APB_MEM_CTRL_STRB_EN
                        strb_q   <= pstrb;
`endif
                        if (pwrite)
                            mem_wdata <= pwdata;
                        if (err_now)
                            prdata <= '0;
                    end
                end
                READ: begin
                    if (!write_q)
                        prdata <= mem_rdata;
`ifdef APB_MEM_CTRL_STRB_EN
                    else
                        mem_wdata <= byte_merge(mem_wdata, mem_rdata, strb_q);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
